// File: rtl/seg_reader.sv
// Reverse decoder for an active-low multiplexed 7-segment bus: synchronizes the pins,
// waits for a stable window, then stores the decoded hex value for the selected digit.
module seg_reader #(
    parameter int NDIGITS       = 2,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W        = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [6:0]             seg,
    input  logic [NDIGITS-1:0]     anode,
    output logic [4*NDIGITS-1:0]   digits,
    output logic [NDIGITS-1:0]     valid,
    output logic                   upd,
    output logic                   bad,
    output logic [IDX_W-1:0]       upd_idx
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int SMP_W = NDIGITS + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic {SETTLE, HELD} state_t;

    logic [SMP_W-1:0] sync_p0;
    logic [SMP_W-1:0] sync_p1;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    state_t           state;
    logic             change;
    logic             capture;
    logic             sel_ok;
    logic [IDX_W-1:0] sel_idx;
    logic [4:0]       dec;

    // Returns {legal, value}; pattern bits are gfedcba, low = lit.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: return 5'h10;
            7'b1111001: return 5'h11;
            7'b0100100: return 5'h12;
            7'b0110000: return 5'h13;
            7'b0011001: return 5'h14;
            7'b0010010: return 5'h15;
            7'b0000010: return 5'h16;
            7'b1111000: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0011000: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b0000011: return 5'h1B;
            7'b1000110: return 5'h1C;
            7'b0100001: return 5'h1D;
            7'b0000110: return 5'h1E;
            7'b0001110: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] low_index(input logic [NDIGITS-1:0] a);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (!a[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // The incoming stage-1 value is compared against the current sample, so the
    // counter already reflects the sample that stage 2 takes on at this edge.
    always_comb begin
        change = (sync_p0 != sync_p1);
        if (change)
            cnt_next = CNT_W'(1);
        else if (cnt == CNT_MAX)
            cnt_next = cnt;
        else
            cnt_next = cnt + 1'b1;
        capture = (cnt_next == CNT_MAX) && ((state == SETTLE) || change);
        sel_ok  = $onehot(~sync_p0[SMP_W-1:7]);
        sel_idx = low_index(sync_p0[SMP_W-1:7]);
        dec     = decode(sync_p0[6:0]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
            cnt     <= '0;
            state   <= SETTLE;
            digits  <= '0;
            valid   <= '0;
            upd     <= 1'b0;
            bad     <= 1'b0;
            upd_idx <= '0;
        end else begin
            sync_p0 <= {anode, seg};
            sync_p1 <= sync_p0;
            cnt     <= cnt_next;
            upd     <= 1'b0;
            bad     <= 1'b0;
            if (capture) begin
                state <= HELD;
                // Blanking or multi-select still consumes the window, silently.
                if (sel_ok) begin
                    upd_idx <= sel_idx;
                    if (dec[4]) begin
                        digits[{sel_idx, 2'b00} +: 4] <= dec[3:0];
                        valid[sel_idx] <= 1'b1;
                        upd            <= 1'b1;
                    end else begin
                        valid[sel_idx] <= 1'b0;
                        bad            <= 1'b1;
                    end
                end
            end else if (change) begin
                state <= SETTLE;
            end
        end
    end

endmodule

// File: tb/tb_seg_reader.sv
// Bench for seg_reader: directed vector table, hand-written latency/reset sequences,
// and randomized traffic checked every cycle against a sample-history model.
module tb_seg_reader;

    localparam int ND = 2;
    localparam int S  = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] seg = 7'h7F;
    logic [1:0] anode = 2'b11;
    logic [7:0] digits;
    logic [1:0] valid;
    logic       upd;
    logic       bad;
    logic [0:0] upd_idx;

    always #5 clk = ~clk;

    seg_reader #(.NDIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clk(clk), .reset_n(reset_n), .seg(seg), .anode(anode),
        .digits(digits), .valid(valid), .upd(upd), .bad(bad), .upd_idx(upd_idx)
    );

    int n_total = 0;
    int n_fail  = 0;

    logic [6:0] pat [16];

    // Model: history of samples seen by the second synchronizer stage since reset.
    logic [8:0] m_stage1;
    logic [8:0] hist [$];
    logic [7:0] m_digits;
    logic [1:0] m_valid;
    logic       m_upd;
    logic       m_bad;
    logic [0:0] m_idx;

    typedef struct {
        logic [1:0] an;
        logic [6:0] sg;
        int         cyc;
        int         n_upd;
        int         n_bad;
        logic [7:0] dig;
        logic [1:0] val;
    } vec_t;
    vec_t vt [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode_ref(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (pat[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_stage1 = '1;
        m_digits = '0;
        m_valid  = '0;
        m_upd    = 1'b0;
        m_bad    = 1'b0;
        m_idx    = '0;
    endtask

    task automatic model_edge();
        logic [8:0] cur;
        int run, zeros, k, v;
        hist.push_back(m_stage1);
        m_stage1 = {anode, seg};
        if (hist.size() > S + 1) void'(hist.pop_front());
        cur = hist[hist.size()-1];
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == cur) run++;
            else break;
        end
        m_upd = 1'b0;
        m_bad = 1'b0;
        if (run == S) begin
            zeros = 0;
            k = 0;
            for (int i = 0; i < ND; i++) begin
                if (!cur[7+i]) begin
                    zeros++;
                    k = i;
                end
            end
            if (zeros == 1) begin
                v = decode_ref(cur[6:0]);
                m_idx = 1'(k);
                if (v >= 0) begin
                    m_digits[4*k +: 4] = 4'(v);
                    m_valid[k] = 1'b1;
                    m_upd = 1'b1;
                end else begin
                    m_valid[k] = 1'b0;
                    m_bad = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_digits", 32'(digits), 32'(m_digits));
        check("model_valid", 32'(valid), 32'(m_valid));
        check("model_upd", 32'(upd), 32'(m_upd));
        check("model_bad", 32'(bad), 32'(m_bad));
        check("model_idx", 32'(upd_idx), 32'(m_idx));
    endtask

    task automatic check_zero(input string name);
        check({name, "_digits"}, 32'(digits), 32'h0);
        check({name, "_valid"}, 32'(valid), 32'h0);
        check({name, "_upd"}, 32'(upd), 32'h0);
        check({name, "_bad"}, 32'(bad), 32'h0);
        check({name, "_idx"}, 32'(upd_idx), 32'h0);
    endtask

    task automatic add(input logic [1:0] an, input logic [6:0] sg, input int cyc,
                       input int nu, input int nb, input logic [7:0] dig, input logic [1:0] val);
        vec_t r;
        r.an = an; r.sg = sg; r.cyc = cyc; r.n_upd = nu; r.n_bad = nb; r.dig = dig; r.val = val;
        vt.push_back(r);
    endtask

    initial begin
        int nu, nb;
        pat[0]  = 7'b1000000; pat[1]  = 7'b1111001; pat[2]  = 7'b0100100; pat[3]  = 7'b0110000;
        pat[4]  = 7'b0011001; pat[5]  = 7'b0010010; pat[6]  = 7'b0000010; pat[7]  = 7'b1111000;
        pat[8]  = 7'b0000000; pat[9]  = 7'b0011000; pat[10] = 7'b0001000; pat[11] = 7'b0000011;
        pat[12] = 7'b1000110; pat[13] = 7'b0100001; pat[14] = 7'b0000110; pat[15] = 7'b0001110;

        // Directed rows, continuing from digit 0 = 3 after the first capture.
        for (int v = 0; v < 16; v++) add(2'b01, pat[v], 10, 1, 0, 8'(v * 16 + 3), 2'b11);
        add(2'b10, 7'b0010010, 10, 1, 0, 8'hF5, 2'b11);
        add(2'b10, 7'b1111111, 10, 0, 1, 8'hF5, 2'b10);
        add(2'b10, 7'b0000000, 10, 1, 0, 8'hF8, 2'b11);
        add(2'b10, 7'b0000010,  3, 0, 0, 8'hF8, 2'b11);
        add(2'b10, 7'b0000000, 10, 1, 0, 8'hF8, 2'b11);
        add(2'b11, 7'b0000000, 10, 0, 0, 8'hF8, 2'b11);
        add(2'b00, 7'b0000000, 10, 0, 0, 8'hF8, 2'b11);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");

        // First capture: pattern present from edge 0 after release, capture at edge 4.
        anode = 2'b10;
        seg = pat[3];
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check("first_upd_time", 32'(upd), 32'(c == 4));
        end
        check("first_digits", 32'(digits), 32'h03);
        check("first_valid", 32'(valid), 32'h1);

        foreach (vt[i]) begin
            anode = vt[i].an;
            seg = vt[i].sg;
            nu = 0;
            nb = 0;
            for (int c = 0; c < vt[i].cyc; c++) begin
                step();
                nu += int'(upd);
                nb += int'(bad);
            end
            check($sformatf("vec%0d_upd_count", i), 32'(nu), 32'(vt[i].n_upd));
            check($sformatf("vec%0d_bad_count", i), 32'(nb), 32'(vt[i].n_bad));
            check($sformatf("vec%0d_digits", i), 32'(digits), 32'(vt[i].dig));
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vt[i].val));
        end

        // Reset two samples into a window on digit 1.
        anode = 2'b01;
        seg = pat[2];
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        check_zero("midreset");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check("mid_upd_time", 32'(upd), 32'(c == 4));
            if (c == 4) check("mid_upd_idx", 32'(upd_idx), 32'h1);
        end
        check("mid_digits", 32'(digits), 32'h20);
        check("mid_valid", 32'(valid), 32'h2);

        // Randomized traffic, including short glitches and illegal codes.
        repeat (200) begin
            case ($urandom_range(0, 5))
                0, 1:    anode = 2'b10;
                2, 3:    anode = 2'b01;
                4:       anode = 2'b11;
                default: anode = 2'b00;
            endcase
            if ($urandom_range(0, 3) != 0) seg = pat[$urandom_range(0, 15)];
            else seg = 7'($urandom);
            repeat ($urandom_range(1, 10)) step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_fail);
        $finish;
    end

endmodule
